// File: rtl/gray_conv_arbiter.sv
// Two-requester gray-to-binary converter with round-robin arbitration.
// Each request is captured in IDLE, converted in CONV and held in DONE until acknowledged.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] g0,
  input  logic             req1,
  input  logic [WIDTH-1:0] g1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_id,
  input  logic             out_ack,
  output logic             busy,
  output logic [7:0]       conv_count
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] g_reg;
  logic             id_reg;
  logic             last_srv;
  logic             pick;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // On a tie the requester that was not served last wins.
  assign pick = (req0 && req1) ? ~last_srv : req1;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      g_reg      <= '0;
      id_reg     <= 1'b0;
      last_srv   <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_id     <= 1'b0;
      conv_count <= 8'd0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            g_reg    <= pick ? g1 : g0;
            id_reg   <= pick;
            last_srv <= pick;
            gnt0     <= ~pick;
            gnt1     <= pick;
            state    <= CONV;
          end
        end
        CONV: begin
          out_bin   <= gray2bin(g_reg);
          out_valid <= 1'b1;
          out_id    <= id_reg;
          state     <= DONE;
        end
        DONE: begin
          if (out_ack) begin
            out_valid  <= 1'b0;
            conv_count <= conv_count + 8'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: vector table plus hand-written tie, stall, reset and wrap sequences.
module tb_gray_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] g0, g1;
  logic       gnt0, gnt1;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_id;
  logic       out_ack;
  logic       busy;
  logic [7:0] conv_count;

  gray_conv_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .g0(g0), .req1(req1), .g1(g1),
    .gnt0(gnt0), .gnt1(gnt1),
    .out_valid(out_valid), .out_bin(out_bin), .out_id(out_id),
    .out_ack(out_ack), .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] g0;
    logic [3:0] g1;
    logic       exp_id;
    logic [3:0] exp_bin;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] bin;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  logic [7:0] count_m;
  logic [3:0] ref_bin [16];
  vec_t       vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expected entry, actual bin=%0h id=%0h", name, out_bin, out_id);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_bin"}, out_bin, e.bin);
      chk({name, "_id"}, out_id, e.id);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_gnt0"}, gnt0, 0);
    chk({name, "_gnt1"}, gnt1, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_bin"}, out_bin, 0);
    chk({name, "_id"}, out_id, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_count"}, conv_count, 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    out_ack = 1'b1;
    #1;
    check_zero(name);
    sb_q.delete();
    count_m = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge with the FSM in IDLE and out_ack high; ends at a negedge back in IDLE.
  task automatic conv(input string name, input logic r0, input logic r1,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic eid, input logic [3:0] ebin);
    exp_t e;
    req0 = r0;
    req1 = r1;
    g0 = a0;
    g1 = a1;
    e.id = eid;
    e.bin = ebin;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_gnt0"}, gnt0, {31'd0, !eid});
    chk({name, "_gnt1"}, gnt1, {31'd0, eid});
    chk({name, "_busy"}, busy, 1);
    chk({name, "_early_valid"}, out_valid, 0);
    if (eid) req1 = 1'b0;
    else     req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_gnt0_off"}, gnt0, 0);
    chk({name, "_gnt1_off"}, gnt1, 0);
    pop_check(name);
    @(posedge clk);
    count_m = count_m + 8'd1;
    @(negedge clk);
    chk({name, "_valid_off"}, out_valid, 0);
    chk({name, "_count"}, conv_count, {24'd0, count_m});
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    g0 = 4'h0;
    g1 = 4'h0;
    out_ack = 1'b1;
    count_m = 8'd0;
    ref_bin = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b0, 1'b1, 4'h0, i[3:0], 1'b1, ref_bin[i]};
    end
    vecs[16] = '{1'b1, 1'b0, 4'h2, 4'h0, 1'b0, 4'h3};
    vecs[17] = '{1'b1, 1'b0, 4'h6, 4'h0, 1'b0, 4'h4};
    vecs[18] = '{1'b1, 1'b0, 4'h9, 4'h0, 1'b0, 4'hE};
    vecs[19] = '{1'b1, 1'b0, 4'hE, 4'h0, 1'b0, 4'hB};

    #1 rst_n = 1'b0;
    #11;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request
    conv("single", 1'b1, 1'b0, 4'b1011, 4'h0, 1'b0, 4'b1101);
    repeat (3) @(negedge clk);
    chk("idle_hold_bin", out_bin, 4'b1101);
    chk("idle_hold_id", out_id, 0);
    chk("idle_hold_valid", out_valid, 0);
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_gnt", {gnt1, gnt0}, 0);
    chk("idle_hold_count", conv_count, 1);

    // Round-robin ties from reset
    do_reset("reset_tie");
    conv("tie1", 1'b1, 1'b1, 4'b1111, 4'b1000, 1'b0, 4'b1010);
    conv("tie2", 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 4'b1111);
    conv("tie3", 1'b1, 1'b1, 4'b1111, 4'b1000, 1'b0, 4'b1010);
    req1 = 1'b0;

    // Vector table: all gray codes on requester 1, a few on requester 0
    for (int i = 0; i < 20; i++) begin
      conv($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].g0, vecs[i].g1,
           vecs[i].exp_id, vecs[i].exp_bin);
    end

    // Stall in DONE with both requests pending
    do_reset("reset_stall");
    out_ack = 1'b0;
    req0 = 1'b1;
    g0 = 4'b0000;
    req1 = 1'b1;
    g1 = 4'b0101;
    sb_q.push_back('{1'b0, 4'b0000});
    @(posedge clk);
    @(negedge clk);
    chk("stall_gnt0", gnt0, 1);
    chk("stall_gnt1", gnt1, 0);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_bin", out_bin, 4'b0000);
      chk("stall_id", out_id, 0);
      chk("stall_busy", busy, 1);
      chk("stall_no_gnt", {gnt1, gnt0}, 0);
      chk("stall_count", conv_count, 0);
    end
    out_ack = 1'b1;
    pop_check("stall");
    @(posedge clk);
    count_m = count_m + 8'd1;
    @(negedge clk);
    chk("stall_release_valid", out_valid, 0);
    chk("stall_release_count", conv_count, 1);
    conv("stall_next", 1'b1, 1'b1, 4'b0000, 4'b0101, 1'b1, 4'b0110);
    req0 = 1'b0;

    // Asynchronous reset while presenting a result
    do_reset("reset_mid_pre");
    out_ack = 1'b0;
    req0 = 1'b1;
    g0 = 4'b0011;
    req1 = 1'b1;
    g1 = 4'b1110;
    @(posedge clk);
    @(negedge clk);
    chk("mid_gnt0", gnt0, 1);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_valid", out_valid, 1);
    chk("mid_bin", out_bin, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    check_zero("async_rst_held");
    rst_n = 1'b1;
    out_ack = 1'b1;
    count_m = 8'd0;
    conv("post_rst", 1'b0, 1'b1, 4'h0, 4'b1110, 1'b1, 4'b1011);

    // Counter wrap
    do_reset("reset_wrap");
    for (int i = 0; i < 256; i++) begin
      conv("wrap", 1'b1, 1'b0, i[3:0], 4'h0, 1'b0, ref_bin[i[3:0]]);
    end
    chk("wrap256", conv_count, 0);
    conv("wrap_last", 1'b0, 1'b1, 4'h0, 4'b0111, 1'b1, 4'b0101);
    chk("wrap257", conv_count, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the gray-code inputs and the binary result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1, conversion request from requester 0.
REQ-005 SHALL have port g0, input, WIDTH, gray code from requester 0; it is valid while req0=1.
REQ-006 SHALL have port req1, input, 1, conversion request from requester 1.
REQ-007 SHALL have port g1, input, WIDTH, gray code from requester 1; it is valid while req1=1.
REQ-008 SHALL have port gnt0 / gnt1, output, 1 each, registered one-cycle pulse meaning "request captured".
REQ-009 SHALL have port out_valid, output, 1, meaning a result is being presented.
REQ-010 SHALL have port out_bin, output, WIDTH, the binary equivalent of the captured gray code.
REQ-011 SHALL have port out_id, output, 1, the index of the requester that owns out_bin.
REQ-012 SHALL have port out_ack, input, 1, consumer acknowledge of the presented result.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 SHALL have port conv_count, output, 8, count of acknowledged conversions.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-016 IDLE: on a clock edge where req0|req1=1, the block SHALL:
- capture the granted requester's g into an internal register g_reg;
- record the requester index;
- pulse the matching gnt for exactly the next cycle;
- move to CONV.
REQ-017 IDLE with no request SHALL remain in IDLE; all outputs hold their values.
REQ-018 Arbitration SHALL be round-robin:
- when only one requester asks, that requester wins;
- when both ask, the requester not served last wins;
- the last-served pointer resets to 1, so req0 wins the first tie.
REQ-019 CONV: on the next edge the block SHALL register out_bin, set out_valid=1 and out_id = the captured index, and move to DONE.
- out_bin[WIDTH-1] = g_reg[WIDTH-1];
- out_bin[i] = out_bin[i+1] XOR g_reg[i], for i from WIDTH-2 down to 0.
REQ-020 DONE SHALL hold out_valid, out_bin and out_id stable until an edge with out_ack=1.
- On that edge: out_valid<=0, conv_count<=conv_count+1 (wrapping 255->0), state<=IDLE.
REQ-021 out_ack outside DONE SHALL be ignored.
REQ-022 Latency SHALL be 2 cycles from the capture edge to out_valid=1; minimum throughput is one conversion per 3 cycles (ack held high).
REQ-023 Requests SHALL be sampled only in IDLE.
- A requester must keep req and g stable until it sees its gnt.
- A req still high when the FSM next reaches IDLE SHALL be treated as a new request.
REQ-024 The losing requester's req SHALL be neither lost nor granted early; it is arbitrated on the next IDLE edge.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE;
- gnt0=gnt1=0, out_valid=0, out_bin=0, out_id=0, busy=0, conv_count=0;
- g_reg=0, last-served pointer=1.
REQ-027 A reset asserted in CONV or DONE SHALL abort the conversion with no ack and no count increment; the first edge after release behaves as IDLE.

Verification
REQ-028 Single request: req0=1, g0=4'b1011, out_ack=1 -> gnt0 pulses 1 cycle after capture; out_valid=1 two cycles after capture with out_bin=4'b1101, out_id=0; conv_count=1.
REQ-029 Tie: req0=req1=1 from reset, g0=4'b1111, g1=4'b1000 -> first result out_bin=4'b1010, out_id=0; second result out_bin=4'b1111, out_id=1; then a further tie grants 0.
REQ-030 Stall: out_ack=0 for 10 cycles in DONE with g=4'b0000 -> out_valid/out_bin=4'b0000/out_id held steady; busy=1; no gnt pulses despite pending requests.
REQ-031 Wrap: 256 acknowledged conversions -> conv_count returns to 0; 257th -> 1.
REQ-032 Reset mid-operation: assert rst_n=0 in DONE -> all outputs 0 asynchronously; after release a pending req1 is granted with correct out_bin.
REQ-033 Exhaustive: all 16 codes g1=4'b0000..4'b1111 -> out_bin matches the gray-to-binary reference value for each.
